// File: rtl/rsa_row_collector.sv
// Collects one row burst of COL_NUM results from the west-edge PE, tags each word with its
// column index, and buffers it in a show-ahead FIFO. Optional row sum: define RSA_COLLECTOR_ROWSUM_EN.
module rsa_row_collector #(
  parameter int RSA_DW     = 32,
  parameter int COL_NUM    = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                            clk,
  input  logic                            sys_rst_n,
  input  logic                            mulres_val,
  input  logic signed [RSA_DW-1:0]        mulres,
  output logic                            out_val,
  input  logic                            out_ready,
  output logic signed [RSA_DW-1:0]        out_data,
  output logic [$clog2(COL_NUM)-1:0]      out_idx,
  output logic                            out_last,
  output logic [$clog2(FIFO_DEPTH):0]     fill_cnt,
  input  logic                            err_clr,
  output logic                            err_ovf,
`ifdef RSA_COLLECTOR_ROWSUM_EN
  output logic                            err_short,
  output logic signed [RSA_DW-1:0]        row_sum,
  output logic                            row_sum_val
`else
  output logic                            err_short
`endif
);

  localparam int IDX_W = $clog2(COL_NUM);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {IDLE, BURST} state_e;

  state_e                   state_q, state_d;
  logic [IDX_W-1:0]         col_q, col_d;
  logic [PTR_W-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]         fill_q, fill_d;
  logic                     ovf_q, short_q;
  logic signed [RSA_DW-1:0] data_mem [FIFO_DEPTH];
  logic [IDX_W-1:0]         idx_mem  [FIFO_DEPTH];

  logic col_last, short_set, full, pop, push_ok, ovf_set;

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    short_set = 1'b0;
    col_last  = (col_q == IDX_W'(COL_NUM - 1));
    if (mulres_val) begin
      col_d   = col_last ? '0 : col_q + IDX_W'(1);
      state_d = col_last ? IDLE : BURST;
    end else if (state_q == BURST) begin
      short_set = 1'b1;
      col_d     = '0;
      state_d   = IDLE;
    end
  end

  // A full FIFO still accepts a word when the head leaves on the same edge.
  always_comb begin
    full    = (fill_q == CNT_W'(FIFO_DEPTH));
    pop     = out_val && out_ready;
    push_ok = mulres_val && (!full || pop);
    ovf_set = mulres_val && full && !pop;
    fill_d  = fill_q + CNT_W'(push_ok) - CNT_W'(pop);
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= IDLE;
      col_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      ovf_q    <= 1'b0;
      short_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      fill_q  <= fill_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      // A set on the same edge as a clear takes priority.
      if (ovf_set)      ovf_q <= 1'b1;
      else if (err_clr) ovf_q <= 1'b0;
      if (short_set)    short_q <= 1'b1;
      else if (err_clr) short_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      data_mem[wr_ptr_q] <= mulres;
      idx_mem[wr_ptr_q]  <= col_q;
    end
  end

  // Head outputs are gated so that an empty buffer presents zeros rather than stale RAM.
  always_comb begin
    out_val  = (fill_q != '0);
    out_data = out_val ? data_mem[rd_ptr_q] : '0;
    out_idx  = out_val ? idx_mem[rd_ptr_q] : '0;
    out_last = out_val && (idx_mem[rd_ptr_q] == IDX_W'(COL_NUM - 1));
    fill_cnt = fill_q;
    err_ovf  = ovf_q;
    err_short = short_q;
  end

`ifdef RSA_COLLECTOR_ROWSUM_EN
  logic signed [RSA_DW-1:0] acc_q, sum_next, row_sum_q;
  logic                     row_sum_val_q;

  // Sums every captured word, dropped or not; a new row restarts at column 0.
  always_comb begin
    sum_next = ((col_q == '0) ? '0 : acc_q) + mulres;
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      acc_q         <= '0;
      row_sum_q     <= '0;
      row_sum_val_q <= 1'b0;
    end else begin
      row_sum_val_q <= 1'b0;
      if (mulres_val) begin
        acc_q <= sum_next;
        if (col_last) begin
          row_sum_q     <= sum_next;
          row_sum_val_q <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    row_sum     = row_sum_q;
    row_sum_val = row_sum_val_q;
  end
`endif

endmodule

// File: tb/tb_rsa_row_collector.sv
// Directed bench for rsa_row_collector: vector table for the basic burst and short-burst
// behaviour, then hand sequences for overflow, full-with-pop, reset mid-burst and row sum.
module tb_rsa_row_collector;

  logic               clk = 1'b0;
  logic               sys_rst_n = 1'b0;
  logic               mulres_val = 1'b0;
  logic signed [31:0] mulres = '0;
  logic               out_val;
  logic               out_ready = 1'b0;
  logic signed [31:0] out_data;
  logic [1:0]         out_idx;
  logic               out_last;
  logic [3:0]         fill_cnt;
  logic               err_clr = 1'b0;
  logic               err_ovf;
  logic               err_short;
`ifdef RSA_COLLECTOR_ROWSUM_EN
  logic signed [31:0] row_sum;
  logic               row_sum_val;
`endif

  int checks = 0;
  int failures = 0;

  rsa_row_collector #(.RSA_DW(32), .COL_NUM(4), .FIFO_DEPTH(8)) dut (
    .clk(clk), .sys_rst_n(sys_rst_n), .mulres_val(mulres_val), .mulres(mulres),
    .out_val(out_val), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
    .out_last(out_last), .fill_cnt(fill_cnt), .err_clr(err_clr), .err_ovf(err_ovf),
`ifdef RSA_COLLECTOR_ROWSUM_EN
    .err_short(err_short), .row_sum(row_sum), .row_sum_val(row_sum_val)
`else
    .err_short(err_short)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        val;
    logic [31:0] data;
    logic        rdy;
    logic        clr;
    logic        eVal;
    logic [31:0] eData;
    logic [31:0] eIdx;
    logic        eLast;
    logic [31:0] eFill;
    logic        eOvf;
    logic        eShort;
    logic        eRsv;
    logic [31:0] eRs;
  } vec_t;

  vec_t vecs[12];

  // Drives one cycle of inputs and returns 1 ns after the capturing edge.
  task automatic applyStimulus(input logic val, input logic [31:0] data,
                               input logic rdy, input logic clr);
    mulres_val = val;
    mulres     = data;
    out_ready  = rdy;
    err_clr    = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkHead(input string tag, input logic v, input logic [31:0] d,
                           input logic [31:0] idx, input logic last, input logic [31:0] fill);
    checkOutput({tag, " out_val"},  32'(out_val),  32'(v));
    checkOutput({tag, " out_data"}, 32'(out_data), d);
    checkOutput({tag, " out_idx"},  32'(out_idx),  idx);
    checkOutput({tag, " out_last"}, 32'(out_last), 32'(last));
    checkOutput({tag, " fill_cnt"}, 32'(fill_cnt), fill);
  endtask

  logic [31:0] drainData[8];

  initial begin
    // Columns: val data rdy clr | val data idx last fill ovf short | rsv rs
    vecs[0]  = '{1'b1, 32'd10, 1'b1, 1'b0, 1'b1, 32'd10, 32'd0, 1'b0, 32'd1, 1'b0, 1'b0, 1'b0, 32'd0};
    vecs[1]  = '{1'b1, 32'd20, 1'b1, 1'b0, 1'b1, 32'd20, 32'd1, 1'b0, 32'd1, 1'b0, 1'b0, 1'b0, 32'd0};
    vecs[2]  = '{1'b1, 32'd30, 1'b1, 1'b0, 1'b1, 32'd30, 32'd2, 1'b0, 32'd1, 1'b0, 1'b0, 1'b0, 32'd0};
    vecs[3]  = '{1'b1, 32'd40, 1'b1, 1'b0, 1'b1, 32'd40, 32'd3, 1'b1, 32'd1, 1'b0, 1'b0, 1'b1, 32'd100};
    vecs[4]  = '{1'b0, 32'd0,  1'b1, 1'b0, 1'b0, 32'd0,  32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd100};
    vecs[5]  = '{1'b1, 32'd5,  1'b0, 1'b0, 1'b1, 32'd5,  32'd0, 1'b0, 32'd1, 1'b0, 1'b0, 1'b0, 32'd100};
    vecs[6]  = '{1'b1, 32'd6,  1'b0, 1'b0, 1'b1, 32'd5,  32'd0, 1'b0, 32'd2, 1'b0, 1'b0, 1'b0, 32'd100};
    vecs[7]  = '{1'b0, 32'd0,  1'b0, 1'b0, 1'b1, 32'd5,  32'd0, 1'b0, 32'd2, 1'b0, 1'b1, 1'b0, 32'd100};
    vecs[8]  = '{1'b1, 32'd7,  1'b0, 1'b0, 1'b1, 32'd5,  32'd0, 1'b0, 32'd3, 1'b0, 1'b1, 1'b0, 32'd100};
    vecs[9]  = '{1'b0, 32'd0,  1'b1, 1'b1, 1'b1, 32'd6,  32'd1, 1'b0, 32'd2, 1'b0, 1'b1, 1'b0, 32'd100};
    vecs[10] = '{1'b0, 32'd0,  1'b1, 1'b1, 1'b1, 32'd7,  32'd0, 1'b0, 32'd1, 1'b0, 1'b0, 1'b0, 32'd100};
    vecs[11] = '{1'b0, 32'd0,  1'b1, 1'b0, 1'b0, 32'd0,  32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd100};

    repeat (2) @(posedge clk);
    #1;
    checkHead("reset", 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    checkOutput("reset err_ovf", 32'(err_ovf), 32'd0);
    checkOutput("reset err_short", 32'(err_short), 32'd0);
`ifdef RSA_COLLECTOR_ROWSUM_EN
    checkOutput("reset row_sum_val", 32'(row_sum_val), 32'd0);
    checkOutput("reset row_sum", 32'(row_sum), 32'd0);
`endif
    @(negedge clk);
    sys_rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].val, vecs[i].data, vecs[i].rdy, vecs[i].clr);
      checkHead($sformatf("vec%0d", i), vecs[i].eVal, vecs[i].eData, vecs[i].eIdx,
                vecs[i].eLast, vecs[i].eFill);
      checkOutput($sformatf("vec%0d err_ovf", i), 32'(err_ovf), 32'(vecs[i].eOvf));
      checkOutput($sformatf("vec%0d err_short", i), 32'(err_short), 32'(vecs[i].eShort));
`ifdef RSA_COLLECTOR_ROWSUM_EN
      checkOutput($sformatf("vec%0d row_sum_val", i), 32'(row_sum_val), 32'(vecs[i].eRsv));
      checkOutput($sformatf("vec%0d row_sum", i), 32'(row_sum), vecs[i].eRs);
`endif
    end

    // Three bursts into a stalled consumer: words 9..12 do not fit.
    for (int i = 1; i <= 12; i++) applyStimulus(1'b1, 32'(i), 1'b0, 1'b0);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
    checkHead("ovf", 1'b1, 32'd1, 32'd0, 1'b0, 32'd8);
    checkOutput("ovf err_ovf", 32'(err_ovf), 32'd1);
    checkOutput("ovf err_short", 32'(err_short), 32'd0);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
    checkOutput("ovf clr err_ovf", 32'(err_ovf), 32'd0);
    checkOutput("ovf clr fill_cnt", 32'(fill_cnt), 32'd8);

    // Full buffer with the consumer draining: every write is accepted.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'(101 + i), 1'b1, 1'b0);
      checkOutput($sformatf("fullpop%0d fill_cnt", i), 32'(fill_cnt), 32'd8);
      checkOutput($sformatf("fullpop%0d err_ovf", i), 32'(err_ovf), 32'd0);
      checkOutput($sformatf("fullpop%0d out_data", i), 32'(out_data), 32'(i + 2));
    end
    drainData = '{32'd5, 32'd6, 32'd7, 32'd8, 32'd101, 32'd102, 32'd103, 32'd104};
    for (int k = 0; k < 8; k++) begin
      checkHead($sformatf("drain%0d", k), 1'b1, drainData[k], 32'(k % 4), (k % 4) == 3,
                32'(8 - k));
      applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    end
    checkHead("drained", 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);

    // Reset in the middle of a burst.
    applyStimulus(1'b1, 32'd50, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'd51, 1'b0, 1'b0);
    mulres_val = 1'b0;
    #2;
    sys_rst_n = 1'b0;
    #1;
    checkHead("midrst", 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    checkOutput("midrst err_ovf", 32'(err_ovf), 32'd0);
    checkOutput("midrst err_short", 32'(err_short), 32'd0);
`ifdef RSA_COLLECTOR_ROWSUM_EN
    checkOutput("midrst row_sum", 32'(row_sum), 32'd0);
`endif
    @(negedge clk);
    sys_rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'(60 + i), 1'b0, 1'b0);
`ifdef RSA_COLLECTOR_ROWSUM_EN
    checkOutput("postrst row_sum_val", 32'(row_sum_val), 32'd1);
    checkOutput("postrst row_sum", 32'(row_sum), 32'd246);
`endif
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
      checkHead($sformatf("postrst%0d", k), 1'b1, 32'(60 + k), 32'(k), k == 3, 32'(4 - k));
      checkOutput($sformatf("postrst%0d err_short", k), 32'(err_short), 32'd0);
      applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    end
    checkOutput("postrst empty", 32'(fill_cnt), 32'd0);

`ifdef RSA_COLLECTOR_ROWSUM_EN
    // Row sum wraps in two's complement.
    applyStimulus(1'b1, 32'h7FFF_FFFF, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'd1, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'd0, 1'b1, 1'b0);
    checkOutput("wrap pre row_sum_val", 32'(row_sum_val), 32'd0);
    applyStimulus(1'b1, 32'd0, 1'b1, 1'b0);
    checkOutput("wrap row_sum_val", 32'(row_sum_val), 32'd1);
    checkOutput("wrap row_sum", 32'(row_sum), 32'h8000_0000);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    checkOutput("wrap pulse end", 32'(row_sum_val), 32'd0);
    checkOutput("wrap hold", 32'(row_sum), 32'h8000_0000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
